// File: rtl/brick_hit_scheduler.sv
// Time-multiplexed bullet-vs-brick collision resolver: scans the brick table once per frame,
// emits one kill per destroyed brick and a hit pulse per requester that destroyed something.
module brick_hit_scheduler #(
   parameter int NUM_BRICK  = 100,
   parameter int BRICK_SIZE = 16,
   parameter int COORD_W    = 10,
   parameter int IDX_W      = 7
) (
   input  logic                 clk_50MHz,
   input  logic                 reset,
   input  logic                 refresh_tick,
   input  logic [COORD_W-1:0]   bullet_size,
   input  logic [2:0]           req_valid,
   input  logic [3*COORD_W-1:0] req_x,
   input  logic [3*COORD_W-1:0] req_y,
   output logic [IDX_W-1:0]     rd_idx,
   input  logic [COORD_W-1:0]   rd_x,
   input  logic [COORD_W-1:0]   rd_y,
   output logic                 kill_valid,
   output logic [IDX_W-1:0]     kill_idx,
   output logic [2:0]           hit,
   output logic                 busy,
   output logic                 overrun
);

   typedef enum logic [2:0] {IDLE, SNAP, SCAN, DRAIN, DONE} state_t;

   localparam int EXT_W = COORD_W + 1;
   localparam logic [EXT_W-1:0] BRICK_M1 = EXT_W'(BRICK_SIZE - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BRICK - 1);

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     rd_idx_q, rd_idx_d;
   logic [2:0]           sh_valid_q, sh_valid_d;
   logic [3*COORD_W-1:0] sh_x_q, sh_x_d;
   logic [3*COORD_W-1:0] sh_y_q, sh_y_d;
   logic [COORD_W-1:0]   sh_size_q, sh_size_d;
   logic                 cmp_valid_q, cmp_valid_d;
   logic [IDX_W-1:0]     cmp_idx_q, cmp_idx_d;
   logic [COORD_W-1:0]   cmp_x_q, cmp_x_d;
   logic [COORD_W-1:0]   cmp_y_q, cmp_y_d;
   logic [2:0]           acc_q, acc_d;
   logic                 overrun_q, overrun_d;
   logic [2:0]           overlap;

   always_ff @(posedge clk_50MHz) begin
      if (reset) begin
         state_q     <= IDLE;
         rd_idx_q    <= '0;
         sh_valid_q  <= '0;
         sh_x_q      <= '0;
         sh_y_q      <= '0;
         sh_size_q   <= '0;
         cmp_valid_q <= 1'b0;
         cmp_idx_q   <= '0;
         cmp_x_q     <= '0;
         cmp_y_q     <= '0;
         acc_q       <= '0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_idx_q    <= rd_idx_d;
         sh_valid_q  <= sh_valid_d;
         sh_x_q      <= sh_x_d;
         sh_y_q      <= sh_y_d;
         sh_size_q   <= sh_size_d;
         cmp_valid_q <= cmp_valid_d;
         cmp_idx_q   <= cmp_idx_d;
         cmp_x_q     <= cmp_x_d;
         cmp_y_q     <= cmp_y_d;
         acc_q       <= acc_d;
         overrun_q   <= overrun_d;
      end
   end

   // Overlap test on the registered brick; widened by one bit so sums near 1023 cannot wrap.
   always_comb begin
      logic [EXT_W-1:0] bx, by, bs, x, y;
      overlap = '0;
      bs = {1'b0, sh_size_q};
      x  = {1'b0, cmp_x_q};
      y  = {1'b0, cmp_y_q};
      for (int r = 0; r < 3; r++) begin
         bx = {1'b0, sh_x_q[r*COORD_W +: COORD_W]};
         by = {1'b0, sh_y_q[r*COORD_W +: COORD_W]};
         overlap[r] = cmp_valid_q && sh_valid_q[r] &&
                      (by < y + BRICK_M1) && (by + bs > y) &&
                      (bx < x + BRICK_M1) && (bx + bs > x);
      end
   end

   always_comb begin
      state_d     = state_q;
      rd_idx_d    = '0;
      sh_valid_d  = sh_valid_q;
      sh_x_d      = sh_x_q;
      sh_y_d      = sh_y_q;
      sh_size_d   = sh_size_q;
      cmp_valid_d = 1'b0;
      cmp_idx_d   = cmp_idx_q;
      cmp_x_d     = cmp_x_q;
      cmp_y_d     = cmp_y_q;
      acc_d       = acc_q | overlap;
      overrun_d   = refresh_tick && (state_q != IDLE);

      case (state_q)
         IDLE: begin
            if (refresh_tick) state_d = SNAP;
         end
         SNAP: begin
            sh_valid_d = req_valid;
            sh_x_d     = req_x;
            sh_y_d     = req_y;
            sh_size_d  = bullet_size;
            acc_d      = '0;
            state_d    = SCAN;
         end
         SCAN: begin
            // Dead (0,0) entries never reach the compare stage as valid.
            cmp_valid_d = (rd_x != '0) || (rd_y != '0);
            cmp_idx_d   = rd_idx_q;
            cmp_x_d     = rd_x;
            cmp_y_d     = rd_y;
            if (rd_idx_q == LAST_IDX) begin
               state_d = DRAIN;
            end else begin
               rd_idx_d = rd_idx_q + 1'b1;
            end
         end
         DRAIN: state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign rd_idx     = rd_idx_q;
   assign kill_valid = |overlap;
   assign kill_idx   = (|overlap) ? cmp_idx_q : '0;
   assign hit        = (state_q == DONE) ? acc_q : 3'b000;
   assign busy       = (state_q != IDLE);
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_brick_hit_scheduler.sv
// Directed bench for brick_hit_scheduler: behavioural brick map plus event logs checked per scenario.
module tb_brick_hit_scheduler;

   localparam int NB = 100;

   logic        clk_50MHz = 1'b0;
   logic        reset;
   logic        refresh_tick;
   logic [9:0]  bullet_size;
   logic [2:0]  req_valid;
   logic [29:0] req_x, req_y;
   logic [6:0]  rd_idx;
   logic [9:0]  rd_x, rd_y;
   logic        kill_valid;
   logic [6:0]  kill_idx;
   logic [2:0]  hit;
   logic        busy;
   logic        overrun;

   logic [9:0] map_x [NB];
   logic [9:0] map_y [NB];

   int cyc = 0;
   int passed = 0;
   int total = 0;

   int kill_cyc[$];
   int kill_id[$];
   int hit_cyc[$];
   int hit_val[$];
   int ovr_cyc[$];

   brick_hit_scheduler dut (
      .clk_50MHz   (clk_50MHz),
      .reset       (reset),
      .refresh_tick(refresh_tick),
      .bullet_size (bullet_size),
      .req_valid   (req_valid),
      .req_x       (req_x),
      .req_y       (req_y),
      .rd_idx      (rd_idx),
      .rd_x        (rd_x),
      .rd_y        (rd_y),
      .kill_valid  (kill_valid),
      .kill_idx    (kill_idx),
      .hit         (hit),
      .busy        (busy),
      .overrun     (overrun)
   );

   always #5 clk_50MHz = ~clk_50MHz;

   always @(posedge clk_50MHz) cyc <= cyc + 1;

   assign rd_x = (int'(rd_idx) < NB) ? map_x[rd_idx] : 10'd0;
   assign rd_y = (int'(rd_idx) < NB) ? map_y[rd_idx] : 10'd0;

   // Event monitor sampling on the falling edge, away from the active edge.
   always @(negedge clk_50MHz) begin
      if (kill_valid) begin
         kill_cyc.push_back(cyc);
         kill_id.push_back(int'(kill_idx));
      end
      if (hit != 3'b000) begin
         hit_cyc.push_back(cyc);
         hit_val.push_back(int'(hit));
      end
      if (overrun) ovr_cyc.push_back(cyc);
   end

   task automatic clear_map();
      for (int i = 0; i < NB; i++) begin
         map_x[i] = '0;
         map_y[i] = '0;
      end
   endtask

   task automatic set_req(input logic [2:0] v, input int x0, input int y0,
                          input int x1, input int y1, input int x2, input int y2);
      req_valid   = v;
      req_x       = {10'(x2), 10'(x1), 10'(x0)};
      req_y       = {10'(y2), 10'(y1), 10'(y0)};
      bullet_size = 10'd4;
   endtask

   // One full scan; requester inputs are scrambled mid-scan to prove they were shadowed.
   task automatic run_scan(output int t0, input int tick2_off);
      @(negedge clk_50MHz);
      refresh_tick = 1'b1;
      t0 = cyc;
      while (cyc < t0 + 105) begin
         @(negedge clk_50MHz);
         refresh_tick = (tick2_off > 0 && cyc == t0 + tick2_off);
         if (cyc == t0 + 3) begin
            req_valid   = 3'b000;
            req_x       = '0;
            req_y       = '0;
            bullet_size = '0;
         end
         if (cyc == t0 + 1) begin
            total++;
            if (busy !== 1'b1) $display("[TB] FAIL busy_start: got %b want 1", busy);
            else passed++;
         end
         if (cyc == t0 + 104) begin
            total++;
            if (busy !== 1'b0) $display("[TB] FAIL busy_end: got %b want 0", busy);
            else passed++;
         end
      end
      refresh_tick = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      refresh_tick = 1'b0;
      set_req(3'b000, 0, 0, 0, 0, 0, 0);
      clear_map();
      repeat (3) @(negedge clk_50MHz);
      total++;
      if ({busy, kill_valid, hit, overrun, rd_idx} !== 13'd0)
         $display("[TB] FAIL reset_outputs: got busy=%b kill=%b hit=%b ovr=%b idx=%0d want all 0",
                  busy, kill_valid, hit, overrun, rd_idx);
      else passed++;
      reset = 1'b0;
   endtask

   task automatic test_reset_mid_scan();
      int nk, nh, guard;
      clear_map();
      map_x[60] = 10'd32; map_y[60] = 10'd96;
      set_req(3'b001, 36, 100, 0, 0, 0, 0);
      nk = kill_id.size();
      nh = hit_val.size();
      @(negedge clk_50MHz);
      refresh_tick = 1'b1;
      @(negedge clk_50MHz);
      refresh_tick = 1'b0;
      guard = 0;
      while (rd_idx != 7'd40 && guard < 200) begin
         @(negedge clk_50MHz);
         guard++;
      end
      total++;
      if (rd_idx !== 7'd40) $display("[TB] FAIL reach_idx40: got %0d want 40", rd_idx);
      else passed++;
      reset = 1'b1;
      @(negedge clk_50MHz);
      total++;
      if (busy !== 1'b0) $display("[TB] FAIL rst_busy: got %b want 0", busy);
      else passed++;
      total++;
      if (kill_valid !== 1'b0 || hit !== 3'b000)
         $display("[TB] FAIL rst_kill_hit: got kill=%b hit=%b want 0/000", kill_valid, hit);
      else passed++;
      total++;
      if (rd_idx !== 7'd0) $display("[TB] FAIL rst_rd_idx: got %0d want 0", rd_idx);
      else passed++;
      reset = 1'b0;
      repeat (120) @(negedge clk_50MHz);
      total++;
      if (kill_id.size() != nk || hit_val.size() != nh)
         $display("[TB] FAIL rst_no_events: got %0d kills %0d hits want 0/0",
                  kill_id.size() - nk, hit_val.size() - nh);
      else passed++;
   endtask

   task automatic test_single_kill();
      int t0, nk, nh;
      clear_map();
      map_x[5] = 10'd32; map_y[5] = 10'd96;
      set_req(3'b001, 36, 100, 0, 0, 0, 0);
      nk = kill_id.size();
      nh = hit_val.size();
      run_scan(t0, 0);
      total++;
      if (kill_id.size() - nk != 1) $display("[TB] FAIL single_kill_count: got %0d want 1", kill_id.size() - nk);
      else passed++;
      total++;
      if (kill_id.size() - nk < 1 || kill_id[nk] != 5 || kill_cyc[nk] != t0 + 8)
         $display("[TB] FAIL single_kill_idx_time: got %0d kills want idx 5 at T+8", kill_id.size() - nk);
      else passed++;
      total++;
      if (hit_val.size() - nh != 1 || hit_val[nh] != 1 || hit_cyc[nh] != t0 + 103)
         $display("[TB] FAIL single_hit: got %0d hit pulses want one 3'b001 at T+103", hit_val.size() - nh);
      else passed++;
   endtask

   task automatic test_shared_brick();
      int t0, nk, nh;
      clear_map();
      map_x[20] = 10'd32; map_y[20] = 10'd96;
      set_req(3'b101, 36, 100, 38, 100, 40, 102);
      nk = kill_id.size();
      nh = hit_val.size();
      run_scan(t0, 0);
      total++;
      if (kill_id.size() - nk != 1 || kill_id[nk] != 20 || kill_cyc[nk] != t0 + 23)
         $display("[TB] FAIL shared_kill: got %0d kills want one idx 20 at T+23", kill_id.size() - nk);
      else passed++;
      total++;
      if (hit_val.size() - nh != 1 || hit_val[nh] != 5)
         $display("[TB] FAIL shared_hit: got %0d pulses want one 3'b101", hit_val.size() - nh);
      else passed++;
   endtask

   task automatic test_back_to_back();
      int t0, nk, nh;
      clear_map();
      map_x[20] = 10'd32; map_y[20] = 10'd96;
      map_x[21] = 10'd48; map_y[21] = 10'd96;
      set_req(3'b001, 46, 100, 0, 0, 0, 0);
      nk = kill_id.size();
      nh = hit_val.size();
      run_scan(t0, 0);
      total++;
      if (kill_id.size() - nk != 2) $display("[TB] FAIL b2b_count: got %0d want 2", kill_id.size() - nk);
      else passed++;
      total++;
      if (kill_id.size() - nk < 2 || kill_id[nk] != 20 || kill_cyc[nk] != t0 + 23 ||
          kill_id[nk+1] != 21 || kill_cyc[nk+1] != t0 + 24)
         $display("[TB] FAIL b2b_order: got %0d kills want idx 20 @T+23, 21 @T+24", kill_id.size() - nk);
      else passed++;
      total++;
      if (hit_val.size() - nh != 1 || hit_val[nh] != 1)
         $display("[TB] FAIL b2b_hit: got %0d pulses want one 3'b001", hit_val.size() - nh);
      else passed++;
   endtask

   task automatic test_dead_and_edge();
      int t0, nk, nh;
      clear_map();
      map_x[2] = 10'd32; map_y[2] = 10'd96;
      set_req(3'b011, 16, 96, 0, 0, 0, 0);
      nk = kill_id.size();
      nh = hit_val.size();
      run_scan(t0, 0);
      total++;
      if (kill_id.size() != nk) $display("[TB] FAIL dead_edge_kills: got %0d want 0", kill_id.size() - nk);
      else passed++;
      total++;
      if (hit_val.size() != nh) $display("[TB] FAIL dead_edge_hit: got %0d pulses want 0", hit_val.size() - nh);
      else passed++;
   endtask

   task automatic test_overrun();
      int t0, t1, nk, nh, no;
      clear_map();
      map_x[5] = 10'd32; map_y[5] = 10'd96;
      set_req(3'b001, 36, 100, 0, 0, 0, 0);
      nk = kill_id.size();
      nh = hit_val.size();
      no = ovr_cyc.size();
      run_scan(t0, 50);
      total++;
      if (ovr_cyc.size() - no != 1 || ovr_cyc[no] != t0 + 51)
         $display("[TB] FAIL overrun_pulse: got %0d pulses want one at T+51", ovr_cyc.size() - no);
      else passed++;
      total++;
      if (kill_id.size() - nk != 1 || hit_val.size() - nh != 1 || hit_cyc[nh] != t0 + 103)
         $display("[TB] FAIL overrun_scan: got %0d kills %0d hits want 1/1 with hit at T+103",
                  kill_id.size() - nk, hit_val.size() - nh);
      else passed++;
      set_req(3'b001, 36, 100, 0, 0, 0, 0);
      nk = kill_id.size();
      run_scan(t1, 0);
      total++;
      if (kill_id.size() - nk != 1 || kill_id[nk] != 5 || kill_cyc[nk] != t1 + 8)
         $display("[TB] FAIL rescan_after_done: got %0d kills want one idx 5 at T+8", kill_id.size() - nk);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_reset_mid_scan();
      test_single_kill();
      test_shared_brick();
      test_back_to_back();
      test_dead_and_edge();
      test_overrun();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
